// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector and its shift-register
// slice: FSM state encoding, default word length, counter sizing.
package serial_word_collector_pkg;

    // Default word length, shared with the transmitting accumulator_shift_reg.
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must hold values 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_collector_sipo_shift_reg.sv
// Serial-in/parallel-out shift register with bit counter. The completing bit
// is merged combinationally into word so the full frame is visible on the
// same edge that done is high.
module sipo_shift_reg
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             capture,
    input  logic             si,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] base_sr;
    logic [WIDTH-1:0] next_sr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    base_cnt;

    // Restart discards the partial frame before the current bit is merged.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, else a latch is inferred.
        base_sr  = sr;
        base_cnt = cnt;
        if (restart) begin
            base_sr  = '0;
            base_cnt = '0;
        end
    end

    generate
        if (LSB_FIRST) begin : g_lsb
            assign next_sr = {si, base_sr[WIDTH-1:1]};
        end else begin : g_msb
            assign next_sr = {base_sr[WIDTH-2:0], si};
        end
    endgenerate

    assign done = capture && (base_cnt == LAST);
    assign word = next_sr;

    // Shift in one bit per qualified strobe; count wraps to zero on completion.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (capture) begin
            sr  <= next_sr;
            cnt <= done ? '0 : base_cnt + 1'b1;
        end else if (restart) begin
            sr  <= '0;
            cnt <= '0;
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Serial receiver: frames WIDTH strobed bits into a word, hands it to a
// holding register with a valid/ack handshake, and flags dropped words.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Si,
    input  logic             SiE,
    input  logic             Pack,
    output logic [WIDTH-1:0] Pout,
    output logic             Pvalid,
    output logic             Busy,
    output logic             Overrun
);

    state_t           state;
    logic             capture;
    logic             done;
    logic [WIDTH-1:0] word;

    // A bit is taken in SHIFT, or in the very cycle a frame starts.
    assign capture = SiE && ((state == SHIFT) || Start);

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_sipo (
        .clk     (CLK),
        .rst     (RST),
        .restart (Start),
        .capture (capture),
        .si      (Si),
        .word    (word),
        .done    (done)
    );

    // Frame FSM; Busy is registered alongside the state it mirrors.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= SHIFT;
                        Busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (done) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: accept a finished word unless the previous one is
    // still unacknowledged, in which case the new one is dropped and flagged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Pout    <= '0;
            Pvalid  <= 1'b0;
            Overrun <= 1'b0;
        end else if (done) begin
            if (!Pvalid || Pack) begin
                Pout   <= word;
                Pvalid <= 1'b1;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Pack && Pvalid) begin
            Pvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: directed scenarios plus a randomized run
// against a queue-based frame model, on an LSB-first and an MSB-first instance.
module tb_serial_word_collector;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST, Start, Si, SiE, Pack;
    logic [W-1:0] pout_l, pout_m;
    logic         pvalid_l, pvalid_m, busy_l, busy_m, ovr_l, ovr_m;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: received bits of the open frame and handshake view.
    bit           q[$];
    bit           m_in_frame, m_pvalid, m_overrun;
    logic [W-1:0] m_pout_l, m_pout_m;

    always #5 CLK = ~CLK;

    serial_word_collector #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .CLK(CLK), .RST(RST), .Start(Start), .Si(Si), .SiE(SiE), .Pack(Pack),
        .Pout(pout_l), .Pvalid(pvalid_l), .Busy(busy_l), .Overrun(ovr_l)
    );

    serial_word_collector #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .CLK(CLK), .RST(RST), .Start(Start), .Si(Si), .SiE(SiE), .Pack(Pack),
        .Pout(pout_m), .Pvalid(pvalid_m), .Busy(busy_m), .Overrun(ovr_m)
    );

    task automatic model_reset();
        q.delete();
        m_in_frame = 1'b0;
        m_pvalid   = 1'b0;
        m_overrun  = 1'b0;
        m_pout_l   = '0;
        m_pout_m   = '0;
    endtask

    task automatic model_step(input bit s, input bit e, input bit d, input bit p);
        bit           completed;
        logic [W-1:0] wl, wm;
        completed = 1'b0;
        wl = '0;
        wm = '0;
        if (s) begin
            q.delete();
            m_in_frame = 1'b1;
        end
        if (e && m_in_frame) begin
            q.push_back(d);
            if (q.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wl[i]       = q[i];
                    wm[W-1-i]   = q[i];
                end
                completed  = 1'b1;
                m_in_frame = 1'b0;
                q.delete();
            end
        end
        if (completed) begin
            if (!m_pvalid || p) begin
                m_pout_l = wl;
                m_pout_m = wm;
                m_pvalid = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
        end else if (p && m_pvalid) begin
            m_pvalid = 1'b0;
        end
    endtask

    // One clock: inputs held across the edge, outputs readable on return.
    task automatic cyc(input bit s, input bit e, input bit d, input bit p);
        Start = s; SiE = e; Si = d; Pack = p;
        @(posedge CLK);
        model_step(s, e, d, p);
        #1;
        Start = 1'b0; SiE = 1'b0; Si = 1'b0; Pack = 1'b0;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Send one frame LSB of w first; optional 1..gap_max idle cycles between bits.
    task automatic send_frame(input logic [W-1:0] w, input int gap_max,
                              input bit pack_last, input bit mid_checks);
        int n;
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                n = (gap_max == 0) ? 0 : $urandom_range(1, gap_max);
                for (int g = 0; g < n; g++) begin
                    cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                    if (mid_checks) begin
                        n_cmp++;
                        if (busy_l !== 1'b1) begin
                            n_err++;
                            $display("FAIL gap_busy: got %b expected 1 (bit %0d)", busy_l, i);
                        end
                        n_cmp++;
                        if (pvalid_l !== 1'b0) begin
                            n_err++;
                            $display("FAIL gap_pvalid: got %b expected 0 (bit %0d)", pvalid_l, i);
                        end
                    end
                end
            end
            cyc(i == 0, 1'b1, w[i], pack_last && (i == W - 1));
        end
    endtask

    task automatic test_reset();
        Start = 0; SiE = 0; Si = 0; Pack = 0;
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if (pout_l !== '0)   begin n_err++; $display("FAIL reset_pout_l: got %h expected 00", pout_l); end
        n_cmp++; if (pout_m !== '0)   begin n_err++; $display("FAIL reset_pout_m: got %h expected 00", pout_m); end
        n_cmp++; if (pvalid_l !== 0)  begin n_err++; $display("FAIL reset_pvalid: got %b expected 0", pvalid_l); end
        n_cmp++; if (busy_l !== 0)    begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_l); end
        n_cmp++; if (ovr_l !== 0)     begin n_err++; $display("FAIL reset_overrun: got %b expected 0", ovr_l); end
        RST = 1'b0;
    endtask

    task automatic test_basic();
        bit b[W];
        b = '{0, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < W; i++) begin
            cyc(i == 0, 1'b1, b[i], 1'b0);
            if (i == W - 2) begin
                n_cmp++;
                if (pvalid_l !== 1'b0) begin n_err++; $display("FAIL basic_early_pvalid: got %b expected 0", pvalid_l); end
                n_cmp++;
                if (busy_l !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy_l); end
            end
        end
        n_cmp++; if (pout_l !== 8'b10100100) begin n_err++; $display("FAIL basic_pout_lsb: got %b expected 10100100", pout_l); end
        n_cmp++; if (pout_m !== 8'b00100101) begin n_err++; $display("FAIL basic_pout_msb: got %b expected 00100101", pout_m); end
        n_cmp++; if (pvalid_l !== 1'b1) begin n_err++; $display("FAIL basic_pvalid: got %b expected 1", pvalid_l); end
        n_cmp++; if (busy_l !== 1'b0)   begin n_err++; $display("FAIL basic_busy_end: got %b expected 0", busy_l); end
        n_cmp++; if (ovr_l !== 1'b0)    begin n_err++; $display("FAIL basic_overrun: got %b expected 0", ovr_l); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (pvalid_m !== 1'b0) begin n_err++; $display("FAIL ack_pvalid: got %b expected 0", pvalid_m); end
        n_cmp++; if (pout_m !== 8'b00100101) begin n_err++; $display("FAIL ack_pout_hold: got %b expected 00100101", pout_m); end
    endtask

    task automatic test_gapped();
        send_frame(8'hFF, 3, 1'b0, 1'b1);
        n_cmp++; if (pout_l !== 8'hFF)  begin n_err++; $display("FAIL gapped_pout: got %h expected ff", pout_l); end
        n_cmp++; if (pvalid_l !== 1'b1) begin n_err++; $display("FAIL gapped_pvalid: got %b expected 1", pvalid_l); end
        n_cmp++; if (busy_l !== 1'b0)   begin n_err++; $display("FAIL gapped_busy_end: got %b expected 0", busy_l); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h5A, 0, 1'b0, 1'b0);
        send_frame(8'hC3, 0, 1'b0, 1'b0);
        n_cmp++; if (pout_l !== 8'h5A) begin n_err++; $display("FAIL b2b_drop_pout: got %h expected 5a", pout_l); end
        n_cmp++; if (ovr_l !== 1'b1)   begin n_err++; $display("FAIL b2b_drop_overrun_l: got %b expected 1", ovr_l); end
        n_cmp++; if (ovr_m !== 1'b1)   begin n_err++; $display("FAIL b2b_drop_overrun_m: got %b expected 1", ovr_m); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ovr_l !== 1'b1)   begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", ovr_l); end
        apply_reset();
        send_frame(8'h5A, 0, 1'b0, 1'b0);
        send_frame(8'hC3, 0, 1'b1, 1'b0);
        n_cmp++; if (pout_l !== 8'hC3)  begin n_err++; $display("FAIL b2b_ack_pout: got %h expected c3", pout_l); end
        n_cmp++; if (pvalid_l !== 1'b1) begin n_err++; $display("FAIL b2b_ack_pvalid: got %b expected 1", pvalid_l); end
        n_cmp++; if (ovr_l !== 1'b0)    begin n_err++; $display("FAIL b2b_ack_overrun: got %b expected 0", ovr_l); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_restart();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (pvalid_l !== 1'b0) begin n_err++; $display("FAIL restart_partial_pvalid: got %b expected 0", pvalid_l); end
        n_cmp++; if (busy_l !== 1'b1)   begin n_err++; $display("FAIL restart_partial_busy: got %b expected 1", busy_l); end
        send_frame(8'h81, 0, 1'b0, 1'b0);
        n_cmp++; if (pout_l !== 8'h81)  begin n_err++; $display("FAIL restart_pout: got %h expected 81", pout_l); end
        n_cmp++; if (pvalid_l !== 1'b1) begin n_err++; $display("FAIL restart_pvalid: got %b expected 1", pvalid_l); end
        n_cmp++; if (ovr_l !== 1'b0)    begin n_err++; $display("FAIL restart_overrun: got %b expected 0", ovr_l); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        #3;
        RST = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (busy_l !== 1'b0)   begin n_err++; $display("FAIL areset_busy: got %b expected 0", busy_l); end
        n_cmp++; if (pvalid_l !== 1'b0) begin n_err++; $display("FAIL areset_pvalid: got %b expected 0", pvalid_l); end
        n_cmp++; if (pout_l !== '0)     begin n_err++; $display("FAIL areset_pout: got %h expected 00", pout_l); end
        n_cmp++; if (ovr_l !== 1'b0)    begin n_err++; $display("FAIL areset_overrun: got %b expected 0", ovr_l); end
        #2;
        RST = 1'b0;
        send_frame(8'h3C, 0, 1'b0, 1'b0);
        n_cmp++; if (pout_l !== 8'h3C)  begin n_err++; $display("FAIL areset_next_pout: got %h expected 3c", pout_l); end
        n_cmp++; if (pvalid_l !== 1'b1) begin n_err++; $display("FAIL areset_next_pvalid: got %b expected 1", pvalid_l); end
    endtask

    task automatic test_random();
        bit s, e, d, p;
        apply_reset();
        for (int c = 0; c < 1200; c++) begin
            s = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 2) != 0);
            d = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 5) == 0);
            cyc(s, e, d, p);
            n_cmp++; if (pout_l !== m_pout_l)   begin n_err++; $display("FAIL rand_pout_l c%0d: got %h expected %h", c, pout_l, m_pout_l); end
            n_cmp++; if (pout_m !== m_pout_m)   begin n_err++; $display("FAIL rand_pout_m c%0d: got %h expected %h", c, pout_m, m_pout_m); end
            n_cmp++; if (pvalid_l !== m_pvalid) begin n_err++; $display("FAIL rand_pvalid c%0d: got %b expected %b", c, pvalid_l, m_pvalid); end
            n_cmp++; if (pvalid_m !== m_pvalid) begin n_err++; $display("FAIL rand_pvalid_m c%0d: got %b expected %b", c, pvalid_m, m_pvalid); end
            n_cmp++; if (busy_l !== m_in_frame) begin n_err++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy_l, m_in_frame); end
            n_cmp++; if (busy_m !== m_in_frame) begin n_err++; $display("FAIL rand_busy_m c%0d: got %b expected %b", c, busy_m, m_in_frame); end
            n_cmp++; if (ovr_l !== m_overrun)   begin n_err++; $display("FAIL rand_overrun c%0d: got %b expected %b", c, ovr_l, m_overrun); end
            n_cmp++; if (ovr_m !== m_overrun)   begin n_err++; $display("FAIL rand_overrun_m c%0d: got %b expected %b", c, ovr_m, m_overrun); end
            if (($urandom_range(0, 199) == 0)) apply_reset();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_restart();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
